ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register's operand, opcode and destination fields (after forwarding). It accepts one M-extension operation at a time. While the operation is in flight it holds the front of the pipeline through `stall_req`, which drives the ID/EX `pause` input. It then returns a 32-bit result with its destination tag for the EX/MEM register.

---
 rtl/ex_muldiv.sv | 149 ++++++++++++++
 tb/tb_ex_muldiv.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit for the EX stage
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply for funct3 0-3 instead of 32-step shift-add.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      done_rd
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     dvs_q, dvs_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rd_q, rd_d;

  logic                a_sgn, b_sgn;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_add, div_shift, div_diff;
  logic [2*XLEN-1:0]   step_next, prod_fix;
  logic [XLEN-1:0]     div_raw, fin;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0]   fprod;
`endif

  // Signedness of each operand follows funct3; MUL uses the unsigned path since low bits match.
  always_comb begin
    a_sgn = a[XLEN-1] & ((op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6));
    b_sgn = b[XLEN-1] & ((op == 3'd1) | (op == 3'd4) | (op == 3'd6));
    a_mag = a_sgn ? -a : a;
    b_mag = b_sgn ? -b : b;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Low 64 bits of the 33x33 signed product are exact for every multiply flavour.
  assign fprod = 64'($signed({a_sgn, a}) * $signed({b_sgn, b}));
`endif

  // acc holds {partial product hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_add   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, dvs_q};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, dvs_q};
    if (op_q[2]) begin
      step_next = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      step_next = acc_q[0] ? {mul_add, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    end
    prod_fix = neg_q ? -step_next : step_next;
    div_raw  = op_q[1] ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
    if (op_q[2])
      fin = neg_q ? -div_raw : div_raw;
    else
      fin = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    dvs_d    = dvs_q;
    acc_d    = acc_q;
    result_d = result_q;
    rd_d     = rd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          rd_d  = rd;
          neg_d = (op == 3'd6) ? a_sgn : (a_sgn ^ b_sgn);
          dvs_d = op[2] ? b_mag : a_mag;
          acc_d = {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
          cnt_d = 5'd0;
          if (op[2] && (b == '0)) begin
            result_d = op[1] ? a : '1;
            state_d  = S_DONE;
          end else if (((op == 3'd4) || (op == 3'd6)) &&
                       (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
            result_d = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!op[2]) begin
            result_d = (op[1:0] == 2'd0) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
            state_d  = S_DONE;
`endif
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = fin;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      dvs_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      dvs_q    <= dvs_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign busy      = (state_q == S_CALC);
  assign done      = (state_q == S_DONE);
  assign stall_req = ~(rst | flush) & (((state_q == S_IDLE) & start) | (state_q == S_CALC));
  assign result    = result_q;
  assign done_rd   = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv (expects MULDIV_FAST_MUL_EN to match the DUT build)
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, flush, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd;
  logic        busy, stall_req, done;
  logic [31:0] result;
  logic [4:0]  done_rd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;
  exp_t sb[$];

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op), .a(a), .b(b), .rd(rd),
    .busy(busy), .stall_req(stall_req), .done(done), .result(result), .done_rd(done_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, p;
    logic [63:0] ux, uy, up;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    p  = '0;
    up = '0;
    case (o)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * $signed(uy); return p[63:32]; end
      3'd3: begin up = ux * uy; return up[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        p = sx / sy;
        return p[31:0];
      end
      3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 32'd0) return x;
        p = sx % sy;
        return p[31:0];
      end
      default: return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 32'd0)) return 1;
    if (((o == 3'd4) || (o == 3'd6)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return 33;
  endfunction

  // Drives one op in the next cycle, holds start until done, then scores the popped expectation.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, output int done_at);
    exp_t e;
    int   n;
    int   stalls;
    bit   seen;
    e.res = model(o, x, y);
    e.rd  = r;
    e.lat = lat_model(o, x, y);
    sb.push_back(e);
    @(negedge clk);
    op = o; a = x; b = y; rd = r; start = 1'b1;
    #1;
    stalls = int'(stall_req);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else if (stall_req) stalls++;
    end
    start = 1'b0;
    done_at = cyc;
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout op=%0d a=%h b=%h: no done within %0d cycles, required %0d", o, x, y, n, e.lat);
    end else begin
      checks++;
      if (result !== e.res) begin
        errors++;
        $display("FAIL result op=%0d a=%h b=%h: got %h required %h", o, x, y, result, e.res);
      end
      checks++;
      if (done_rd !== e.rd) begin
        errors++;
        $display("FAIL done_rd op=%0d: got %0d required %0d", o, done_rd, e.rd);
      end
      checks++;
      if (n != e.lat || stalls != e.lat) begin
        errors++;
        $display("FAIL latency op=%0d a=%h b=%h: done at %0d with %0d stalls, required %0d and %0d",
                 o, x, y, n, stalls, e.lat, e.lat);
      end
      checks++;
      if (stall_req !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_state: stall_req=%b busy=%b, required 0 0", stall_req, busy);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; op = 3'd5; a = 32'd9; b = 32'd3; rd = 5'd7;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b required 0", stall_req);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, stall_req} !== 3'b000 || result !== 32'd0 || done_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b stall=%b result=%h rd=%0d required all 0",
               busy, done, stall_req, result, done_rd);
    end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_mul;
    int t;
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, t);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, t);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, t);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, t);
  endtask

  task automatic test_div;
    int t;
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, t);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, t);
    do_op(3'd5, 32'd100, 32'd7, 5'd12, t);
    do_op(3'd7, 32'd100, 32'd7, 5'd13, t);
  endtask

  task automatic test_special;
    int t;
    do_op(3'd4, 32'd5, 32'd0, 5'd20, t);
    do_op(3'd7, 32'd5, 32'd0, 5'd21, t);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, t);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, t);
  endtask

  task automatic test_random;
    int t;
    for (int i = 0; i < 12; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      do_op(3'($urandom_range(0, 7)), x, y, 5'($urandom_range(0, 31)), t);
    end
  endtask

  task automatic test_flush;
    int t;
    bit stray;
    // flush with start in IDLE must not accept the op
    @(negedge clk);
    op = 3'd5; a = 32'd50; b = 32'd5; rd = 5'd4; start = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_stall: got %b required 0", stall_req);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_state: busy=%b done=%b required 0 0", busy, done);
    end
    flush = 1'b0; start = 1'b0;
    // abort at CALC cycle 10
    @(negedge clk);
    op = 3'd5; a = 32'd100; b = 32'd7; rd = 5'd6; start = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL calc_busy: got %b required 1", busy);
    end
    flush = 1'b1; start = 1'b0;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b required 0", stall_req);
    end
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || stall_req !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b stall=%b done=%b required 0 0 0", busy, stall_req, done);
    end
    stray = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL flush_no_done: got a done pulse, required none");
    end
    do_op(3'd5, 32'd9, 32'd3, 5'd8, t);
  endtask

  task automatic test_rst_mid;
    @(negedge clk);
    op = 3'd7; a = 32'd1234; b = 32'd10; rd = 5'd9; start = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, stall_req} !== 3'b000 || result !== 32'd0 || done_rd !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b stall=%b result=%h rd=%0d required all 0",
               busy, done, stall_req, result, done_rd);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    int t1, t2;
    do_op(3'd5, 32'd1000, 32'd10, 5'd3, t1);
    do_op(3'd5, 32'd77, 32'd5, 5'd9, t2);
    checks++;
    if (t2 - t1 != 34) begin
      errors++;
      $display("FAIL back_to_back_spacing: got %0d cycles required 34", t2 - t1);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; rd = '0;
    @(negedge clk);
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_random;
    test_flush;
    test_rst_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
